// File: rtl/systolic_array_pkg.sv
// -----------------------------------------------------------------------------
// systolic_array_pkg
//
// Purpose:
//   Shared constants and arithmetic helpers for the 3x3 output-stationary
//   systolic matrix-multiply array.
//
// Contents:
//   N       - array dimension (rows = columns)
//   DATA_W  - unsigned operand width
//   ACC_W   - per-PE accumulator width
//   BUS_W   - width of one packed edge-operand bus (N lanes of DATA_W)
//   OUT_W   - width of one packed accumulator output bus (N lanes of ACC_W)
//   mac_wrap() - unsigned multiply-accumulate, wrapping modulo 2^ACC_W
// -----------------------------------------------------------------------------
package systolic_array_pkg;

    localparam int N      = 3;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 16;
    localparam int PROD_W = 2 * DATA_W;
    localparam int BUS_W  = N * DATA_W;
    localparam int OUT_W  = N * ACC_W;

    // Full-width unsigned product added into the accumulator. The sum is
    // truncated to ACC_W bits, so overflow silently wraps; there is no
    // saturation and no overflow indication.
    function automatic logic [ACC_W-1:0] mac_wrap(
        input logic [ACC_W-1:0]  acc,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [PROD_W-1:0] prod;
        prod = a * b;
        return acc + ACC_W'(prod);
    endfunction

endpackage : systolic_array_pkg

// File: rtl/systolic_array_if.sv
// -----------------------------------------------------------------------------
// systolic_array_if
//
// Purpose:
//   Bundles the edge operand buses and the exposed accumulator buses of the
//   systolic array into one interface.
//
// Signals:
//   datain   [BUS_W-1:0]  left-edge row operands, row 0 in the MSBs
//   weightin [BUS_W-1:0]  top-edge column operands, col 0 in the MSBs
//   macouti  [OUT_W-1:0]  right-column accumulators, row 0 in the MSBs
//   macoutj  [OUT_W-1:0]  bottom-row accumulators, col 0 in the MSBs
//
// Modports:
//   master - operand driver (testbench / upstream sequencer)
//   slave  - the systolic array itself
// -----------------------------------------------------------------------------
interface systolic_array_if;
    import systolic_array_pkg::*;

    logic [BUS_W-1:0] datain;
    logic [BUS_W-1:0] weightin;
    logic [OUT_W-1:0] macouti;
    logic [OUT_W-1:0] macoutj;

    modport master (
        output datain,
        output weightin,
        input  macouti,
        input  macoutj
    );

    modport slave (
        input  datain,
        input  weightin,
        output macouti,
        output macoutj
    );

endinterface : systolic_array_if

// File: rtl/systolic_array_pe.sv
// -----------------------------------------------------------------------------
// systolic_pe
//
// Purpose:
//   One processing element of the output-stationary systolic array. Every
//   clock it forwards its row operand to the right and its column operand
//   downward through one register each, and adds the product of the two
//   incoming operands into its local accumulator.
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous active-low reset; clears all state
//   a_i    in   row operand from the left neighbour (or left edge)
//   b_i    in   column operand from the upper neighbour (or top edge)
//   a_o    out  registered copy of a_i for the right neighbour
//   b_o    out  registered copy of b_i for the lower neighbour
//   acc_o  out  accumulator, direct register output
// -----------------------------------------------------------------------------
module systolic_pe
    import systolic_array_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] a_o,
    output logic [DATA_W-1:0] b_o,
    output logic [ACC_W-1:0]  acc_o
);

    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  acc_d;

    // The product uses the unregistered inputs, so the operand pair that is
    // forwarded on this edge is the same pair accumulated on this edge.
    always_comb begin
        acc_d = mac_wrap(acc_q, a_i, b_i);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_i;
            b_q   <= b_i;
            acc_q <= acc_d;
        end
    end

    assign a_o   = a_q;
    assign b_o   = b_q;
    assign acc_o = acc_q;

endmodule : systolic_pe

// File: rtl/systolic_array.sv
// -----------------------------------------------------------------------------
// systolic_array
//
// Purpose:
//   N x N output-stationary systolic array computing C = A x B with unsigned
//   DATA_W operands and ACC_W wrapping accumulators. Row operands enter on
//   the left edge and ripple right; column operands enter on the top edge
//   and ripple down. PE(i,j) ends up holding C(i,j).
//
//   The driver is responsible for the operand skew: row i of A is presented
//   i cycles late and column j of B j cycles late, with idle lanes at zero.
//   PE(i,j) holds its final value after edge e0+i+j+N-1, e0 being the first
//   edge that samples element 0. Accumulators never self-clear; only reset
//   starts a new product.
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous active-low reset; clears every PE
//   bus    slave modport of systolic_array_if:
//            datain / weightin  skewed edge operands (lane 0 in the MSBs)
//            macouti            right-column accumulators, row 0 in the MSBs
//            macoutj            bottom-row accumulators, col 0 in the MSBs
//
//   This level is wiring only: operand lane unpacking, the PE mesh and the
//   output packing. Outputs come straight from PE accumulator registers.
// -----------------------------------------------------------------------------
module systolic_array
    import systolic_array_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    systolic_array_if.slave bus
);

    // a_w[i][j] is the row operand entering PE(i,j); column N is the
    // pass-through out of the right edge, which nothing consumes.
    logic [DATA_W-1:0] a_w   [N][N+1];
    // b_w[i][j] is the column operand entering PE(i,j); row N falls off the
    // bottom edge.
    logic [DATA_W-1:0] b_w   [N+1][N];
    logic [ACC_W-1:0]  acc_w [N][N];

    // Edge lanes feed the first column / first row directly, lane 0 in the
    // most significant byte of each bus.
    for (genvar gi = 0; gi < N; gi++) begin : g_left_edge
        assign a_w[gi][0] = bus.datain[(N-1-gi)*DATA_W +: DATA_W];
    end

    for (genvar gj = 0; gj < N; gj++) begin : g_top_edge
        assign b_w[0][gj] = bus.weightin[(N-1-gj)*DATA_W +: DATA_W];
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            systolic_pe u_pe (
                .clk   (clk),
                .reset (reset),
                .a_i   (a_w[gi][gj]),
                .b_i   (b_w[gi][gj]),
                .a_o   (a_w[gi][gj+1]),
                .b_o   (b_w[gi+1][gj]),
                .acc_o (acc_w[gi][gj])
            );
        end
    end

    // Right column goes to macouti, bottom row to macoutj; PE(N-1,N-1)
    // appears in the LSB lane of both buses.
    for (genvar gk = 0; gk < N; gk++) begin : g_out_pack
        assign bus.macouti[(N-1-gk)*ACC_W +: ACC_W] = acc_w[gk][N-1];
        assign bus.macoutj[(N-1-gk)*ACC_W +: ACC_W] = acc_w[N-1][gk];
    end

endmodule : systolic_array

// File: tb/tb_systolic_array.sv
module tb_systolic_array;
    import systolic_array_pkg::*;

    typedef logic [N*N-1:0][DATA_W-1:0] mat_t;   // element [r][c] at index r*N+c

    typedef struct packed {
        mat_t             a;
        mat_t             b;
        logic [OUT_W-1:0] exp_i;
        logic [OUT_W-1:0] exp_j;
    } vec_t;

    localparam int NVEC = 4;
    localparam int LAST = 3 * N - 3;   // edge index after which PE(N-1,N-1) is final

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    systolic_array_if bus ();

    systolic_array dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------------------------------------------------------- helpers
    task automatic cmp(input string name, input logic [OUT_W-1:0] act,
                       input logic [OUT_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Reference: after edge t, PE(i,j) has absorbed exactly those terms
    // A[i][k]*B[k][j] whose operands met there, i.e. k+i+j <= t.
    function automatic logic [ACC_W-1:0] partial(mat_t a, mat_t b, int i, int j, int t);
        int s = 0;
        for (int k = 0; k < N; k++)
            if (k + i + j <= t)
                s += int'(a[i*N+k]) * int'(b[k*N+j]);
        return s[ACC_W-1:0];
    endfunction

    function automatic logic [OUT_W-1:0] model_i(mat_t a, mat_t b, int t);
        logic [OUT_W-1:0] r = '0;
        for (int i = 0; i < N; i++) r[(N-1-i)*ACC_W +: ACC_W] = partial(a, b, i, N-1, t);
        return r;
    endfunction

    function automatic logic [OUT_W-1:0] model_j(mat_t a, mat_t b, int t);
        logic [OUT_W-1:0] r = '0;
        for (int j = 0; j < N; j++) r[(N-1-j)*ACC_W +: ACC_W] = partial(a, b, N-1, j, t);
        return r;
    endfunction

    // Skewed edge lanes for edge t: lane L carries element t-L.
    function automatic logic [BUS_W-1:0] skew_a(mat_t a, int t);
        logic [BUS_W-1:0] v = '0;
        for (int i = 0; i < N; i++)
            if (t - i >= 0 && t - i < N) v[(N-1-i)*DATA_W +: DATA_W] = a[i*N + (t-i)];
        return v;
    endfunction

    function automatic logic [BUS_W-1:0] skew_b(mat_t b, int t);
        logic [BUS_W-1:0] v = '0;
        for (int j = 0; j < N; j++)
            if (t - j >= 0 && t - j < N) v[(N-1-j)*DATA_W +: DATA_W] = b[(t-j)*N + j];
        return v;
    endfunction

    // Drive edges t0..t1 of the skewed feed; optionally check the model after each.
    task automatic run_edges(input mat_t a, input mat_t b, input int t0, input int t1,
                             input bit chk, input string tag);
        for (int t = t0; t <= t1; t++) begin
            bus.datain   = skew_a(a, t);
            bus.weightin = skew_b(b, t);
            @(posedge clk);
            #1;
            if (chk) begin
                cmp($sformatf("%s_i_e%0d", tag, t), bus.macouti, model_i(a, b, t));
                cmp($sformatf("%s_j_e%0d", tag, t), bus.macoutj, model_j(a, b, t));
            end
        end
    endtask

    // Reset pulse with random operands driven; outputs must stay zero.
    task automatic do_reset(input string tag);
        bus.datain   = BUS_W'($urandom);
        bus.weightin = BUS_W'($urandom);
        @(negedge clk);
        reset = 1'b0;
        #1;
        cmp({tag, "_assert_i"}, bus.macouti, '0);
        cmp({tag, "_assert_j"}, bus.macoutj, '0);
        repeat (2) begin
            @(posedge clk);
            bus.datain   = BUS_W'($urandom);
            bus.weightin = BUS_W'($urandom);
            #1;
            cmp({tag, "_held_i"}, bus.macouti, '0);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        cmp({tag, "_release_i"}, bus.macouti, '0);
        cmp({tag, "_release_j"}, bus.macoutj, '0);
    endtask

    // ------------------------------------------------------------------ test
    vec_t vecs [NVEC];
    mat_t am, bm, ra, rb;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        reset        = 1'b0;
        bus.datain   = BUS_W'($urandom);
        bus.weightin = BUS_W'($urandom);
        #1;
        cmp("por_i", bus.macouti, '0);
        cmp("por_j", bus.macoutj, '0);

        // Reference matrices: A rows [1,2,3],[4,5,6],[7,8,9];
        // B columns [2,4,6],[1,5,9],[3,7,8].
        am = '0; bm = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                am[r*N+c] = DATA_W'(r*N + c + 1);
        bm[0] = 2; bm[3] = 4; bm[6] = 6;
        bm[1] = 1; bm[4] = 5; bm[7] = 9;
        bm[2] = 3; bm[5] = 7; bm[8] = 8;

        vecs[0].a = am; vecs[0].b = bm;
        vecs[0].exp_i = {16'd41, 16'd95, 16'd149};
        vecs[0].exp_j = {16'd100, 16'd128, 16'd149};

        vecs[1].a = '1; vecs[1].b = '1;
        vecs[1].exp_i = {3{16'hFA03}};
        vecs[1].exp_j = {3{16'hFA03}};

        vecs[2].a = '0;                      // identity: C = B
        vecs[2].a[0] = 1; vecs[2].a[4] = 1; vecs[2].a[8] = 1;
        vecs[2].b = bm;
        vecs[2].exp_i = {16'd3, 16'd7, 16'd8};
        vecs[2].exp_j = {16'd6, 16'd9, 16'd8};

        vecs[3].a = {N*N{8'd1}};             // all ones: C = column sums of B
        vecs[3].b = bm;
        vecs[3].exp_i = {16'd18, 16'd18, 16'd18};
        vecs[3].exp_j = {16'd12, 16'd15, 16'd18};

        do_reset("reset");

        // Table-driven products, then 10 idle cycles must hold the result.
        for (int v = 0; v < NVEC; v++) begin
            do_reset($sformatf("rst_v%0d", v));
            run_edges(vecs[v].a, vecs[v].b, 0, LAST, 1'b0, "tbl");
            cmp($sformatf("vec%0d_macouti", v), bus.macouti, vecs[v].exp_i);
            cmp($sformatf("vec%0d_macoutj", v), bus.macoutj, vecs[v].exp_j);
            run_edges(vecs[v].a, vecs[v].b, LAST + 1, LAST + 10, 1'b0, "hold");
            cmp($sformatf("vec%0d_hold_i", v), bus.macouti, vecs[v].exp_i);
            cmp($sformatf("vec%0d_hold_j", v), bus.macoutj, vecs[v].exp_j);
        end

        // Latency: top-right PE completes after edge 4 (17 after edge 3),
        // bottom-right after edge 6 (77 after edge 5).
        do_reset("rst_lat");
        for (int t = 0; t <= LAST; t++) begin
            run_edges(am, bm, t, t, 1'b0, "lat");
            if (t == 3) cmp("lat_top_e3",    OUT_W'(bus.macouti[47:32]), OUT_W'(16'd17));
            if (t == 4) cmp("lat_top_e4",    OUT_W'(bus.macouti[47:32]), OUT_W'(16'd41));
            if (t == 5) cmp("lat_bottom_e5", OUT_W'(bus.macouti[15:0]),  OUT_W'(16'd77));
            if (t == 6) cmp("lat_bottom_e6", OUT_W'(bus.macouti[15:0]),  OUT_W'(16'd149));
        end

        // Mid-operation asynchronous reset, then a clean rerun.
        do_reset("rst_mid");
        run_edges(am, bm, 0, 2, 1'b0, "mid");
        #2;
        reset = 1'b0;
        #1;
        cmp("mid_async_i", bus.macouti, '0);
        cmp("mid_async_j", bus.macoutj, '0);
        @(negedge clk);
        reset = 1'b1;
        run_edges(am, bm, 0, LAST, 1'b0, "rerun");
        cmp("rerun_macouti", bus.macouti, {16'd41, 16'd95, 16'd149});
        cmp("rerun_macoutj", bus.macoutj, {16'd100, 16'd128, 16'd149});

        // Randomized matrices checked edge-by-edge against the partial-sum model.
        for (int it = 0; it < 20; it++) begin
            for (int e = 0; e < N*N; e++) begin
                ra[e] = DATA_W'($urandom);
                rb[e] = DATA_W'($urandom);
            end
            if (it % 5 == 0) begin
                ra[$urandom_range(N*N-1)] = 8'hFF;
                rb[$urandom_range(N*N-1)] = 8'hFF;
            end
            do_reset($sformatf("rst_rnd%0d", it));
            run_edges(ra, rb, 0, LAST + 2, 1'b1, $sformatf("rnd%0d", it));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_systolic_array
